// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter and its round-robin sub-block.
package dmem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers who was granted last and favours the other on a tie.
import dmem_pkg::*;

module rr_arb2 (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   req_cpu,
  input  logic   req_host,
  output logic   gnt_cpu,
  output logic   gnt_host,
  output owner_t last
);

  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_host = 1'b0;
    if (en) begin
      if (req_cpu && req_host) begin
        gnt_cpu  = (last == OWN_HOST);
        gnt_host = (last == OWN_CPU);
      end else begin
        gnt_cpu  = req_cpu;
        gnt_host = req_host;
      end
    end
  end

  // Host counts as last owner out of reset so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= OWN_HOST;
    end else if (gnt_cpu) begin
      last <= OWN_CPU;
    end else if (gnt_host) begin
      last <= OWN_HOST;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and host access to a synchronous single-port data memory (IDLE -> ACCESS -> RDATA).
import dmem_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cpu_cnt,
  output logic [CNT_W-1:0]  host_cnt
);

  state_t            state, state_nxt;
  owner_t            owner;
  logic              arb_en;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

  // Requests are only looked at in IDLE, and never while reset is held.
  assign arb_en = (state == IDLE) && reset;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (arb_en),
    .req_cpu  (cpu_req),
    .req_host (host_req),
    .gnt_cpu  (cpu_gnt),
    .gnt_host (host_gnt),
    .last     (owner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_wr doubles as the latched access type while in ACCESS.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_gnt || host_gnt) state_nxt = ACCESS;
      ACCESS:  state_nxt = mem_wr ? IDLE : RDATA;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The memory port registers are the latch for the granted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (cpu_gnt) begin
      mem_wr    <= cpu_wr;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end else if (host_gnt) begin
      mem_wr    <= host_wr;
      mem_addr  <= host_addr;
      mem_wdata <= host_wdata;
    end else begin
      mem_wr    <= 1'b0;
    end
  end

  assign cpu_rvalid  = (state == RDATA) && (owner == OWN_CPU);
  assign host_rvalid = (state == RDATA) && (owner == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
  assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
      if (host_rvalid) host_rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_cnt  <= '0;
      host_cnt <= '0;
    end else begin
      if (cpu_gnt)  cpu_cnt  <= sat_inc(cpu_cnt);
      if (host_gnt) host_cnt <= sat_inc(host_cnt);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        host_req = 1'b0, host_wr = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_wr;
  logic [15:0] cpu_rdata, host_rdata, mem_wdata, cpu_cnt, host_cnt;
  logic [15:0] mem_rdata = '0;
  logic [7:0]  mem_addr;

  bit [15:0] tb_mem  [256];
  bit [15:0] ref_mem [256];
  bit        last_host;
  int        cnt_cpu_m, cnt_host_m;
  int        tests = 0, fails = 0;
  int        cyc = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_cnt(cpu_cnt), .host_cnt(host_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory: read data appears one clock after the address.
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset;
    last_host  = 1'b1;
    cnt_cpu_m  = 0;
    cnt_host_m = 0;
  endtask

  task automatic wait_gnt(input bit host, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host ? host_gnt : cpu_gnt) begin
        ok = 1'b1;
        t  = cyc;
        return;
      end
    end
  endtask

  task automatic cpu_txn(input bit wr, input logic [7:0] a, input logic [15:0] d, output bit ok);
    int t;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    wait_gnt(1'b0, ok, t);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cpu_req = 1'b1; host_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (mem_wr !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("[TB] FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    tests++; if (mem_wdata !== 16'h0000) begin fails++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
    tests++; if ({cpu_gnt, host_gnt} !== 2'b00) begin fails++; $display("[TB] FAIL reset_gnt: got %b expected 00", {cpu_gnt, host_gnt}); end
    tests++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin fails++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {cpu_rvalid, host_rvalid}); end
    tests++; if ({cpu_rdata, host_rdata} !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 0", {cpu_rdata, host_rdata}); end
    tests++; if ({cpu_cnt, host_cnt} !== 32'h0) begin fails++; $display("[TB] FAIL reset_cnt: got %h expected 0", {cpu_cnt, host_cnt}); end
    cpu_req = 1'b0; host_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_cpu_write;
    bit ok;
    int t;
    idle(2);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'h1234;
    wait_gnt(1'b0, ok, t);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL wr_gnt: got no cpu_gnt expected one"); end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    tests++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 8'h10, 16'h1234})
      begin fails++; $display("[TB] FAIL wr_access: got %b/%h/%h expected 1/10/1234", mem_wr, mem_addr, mem_wdata); end
    tests++; if (cpu_gnt !== 1'b0) begin fails++; $display("[TB] FAIL wr_gnt_pulse: got %b expected 0", cpu_gnt); end
    @(negedge clk);
    tests++; if (mem_wr !== 1'b0) begin fails++; $display("[TB] FAIL wr_done: got mem_wr %b expected 0", mem_wr); end
    ref_mem[8'h10] = 16'h1234;
    last_host = 1'b0;
    cnt_cpu_m = sat16(cnt_cpu_m);
    tests++; if (cpu_cnt !== 16'(cnt_cpu_m)) begin fails++; $display("[TB] FAIL wr_cnt: got %0d expected %0d", cpu_cnt, cnt_cpu_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_host_read;
    bit ok;
    int t;
    idle(2);
    host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h10;
    wait_gnt(1'b1, ok, t);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL rd_gnt: got no host_gnt expected one"); end
    @(posedge clk); #1;
    host_req = 1'b0;
    @(negedge clk);
    tests++; if (host_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rd_early: got host_rvalid %b expected 0", host_rvalid); end
    @(negedge clk);
    tests++; if ({host_rvalid, host_rdata, cpu_rvalid} !== {1'b1, ref_mem[8'h10], 1'b0})
      begin fails++; $display("[TB] FAIL rd_data: got %b/%h/%b expected 1/%h/0", host_rvalid, host_rdata, cpu_rvalid, ref_mem[8'h10]); end
    @(negedge clk);
    tests++; if ({host_rvalid, host_rdata} !== {1'b0, 16'h1234})
      begin fails++; $display("[TB] FAIL rd_hold: got %b/%h expected 0/1234", host_rvalid, host_rdata); end
    last_host = 1'b1;
    cnt_host_m = sat16(cnt_host_m);
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    int free_at, exp_rd_cycle, n;
    bit exp_rd_host;
    logic [15:0] exp_rd_data;
    idle(3);
    free_at = cyc; exp_rd_cycle = -1; n = 0; exp_rd_host = 1'b0; exp_rd_data = '0;
    cpu_req = 1'b1; host_req = 1'b1; cpu_wr = 1'b0; host_wr = 1'b0;
    cpu_addr = 8'($urandom_range(0, 15)); host_addr = 8'($urandom_range(0, 15));
    for (int c = 0; c < 40; c++) begin
      bit g_cpu, g_host;
      logic [15:0] rd;
      @(negedge clk);
      g_cpu = 1'b0; g_host = 1'b0;
      if (cyc >= free_at && cpu_req && host_req) begin g_cpu = last_host; g_host = !last_host; end
      tests++; if ({cpu_gnt, host_gnt} !== {g_cpu, g_host})
        begin fails++; $display("[TB] FAIL rr_gnt cycle %0d: got %b expected %b", cyc, {cpu_gnt, host_gnt}, {g_cpu, g_host}); end
      if (cyc == exp_rd_cycle) begin
        rd = exp_rd_host ? host_rdata : cpu_rdata;
        tests++; if ({cpu_rvalid, host_rvalid, rd} !== {!exp_rd_host, exp_rd_host, exp_rd_data})
          begin fails++; $display("[TB] FAIL rr_rdata: got %b%b/%h expected %b%b/%h", cpu_rvalid, host_rvalid, rd, !exp_rd_host, exp_rd_host, exp_rd_data); end
      end
      if (g_cpu || g_host) begin
        if (n == 0) begin
          tests++; if (cpu_gnt !== 1'b1) begin fails++; $display("[TB] FAIL rr_first: got cpu_gnt %b expected 1", cpu_gnt); end
        end
        exp_rd_cycle = cyc + 2;
        exp_rd_host  = g_host;
        exp_rd_data  = ref_mem[g_host ? host_addr : cpu_addr];
        free_at      = cyc + 3;
        last_host    = g_host;
        if (g_cpu) cnt_cpu_m = sat16(cnt_cpu_m); else cnt_host_m = sat16(cnt_host_m);
        n++;
      end
      @(posedge clk); #1;
      if (n >= 8) begin cpu_req = 1'b0; host_req = 1'b0; end
      else if (g_cpu) cpu_addr = 8'($urandom_range(0, 15));
      else if (g_host) host_addr = 8'($urandom_range(0, 15));
    end
    tests++; if ({cpu_cnt, host_cnt} !== {16'(cnt_cpu_m), 16'(cnt_host_m)})
      begin fails++; $display("[TB] FAIL rr_cnt: got %0d/%0d expected %0d/%0d", cpu_cnt, host_cnt, cnt_cpu_m, cnt_host_m); end
  endtask

  task automatic test_random;
    int free_at, exp_rd_cycle;
    bit exp_rd_host;
    logic [15:0] exp_rd_data;
    idle(3);
    free_at = cyc; exp_rd_cycle = -1; exp_rd_host = 1'b0; exp_rd_data = '0;
    for (int c = 0; c < 400; c++) begin
      bit g_cpu, g_host, wr;
      logic [7:0] a;
      logic [15:0] rd;
      @(negedge clk);
      g_cpu = 1'b0; g_host = 1'b0;
      if (cyc >= free_at) begin
        if (cpu_req && host_req) begin g_cpu = last_host; g_host = !last_host; end
        else begin g_cpu = cpu_req; g_host = host_req; end
      end
      tests++; if ({cpu_gnt, host_gnt} !== {g_cpu, g_host})
        begin fails++; $display("[TB] FAIL rand_gnt cycle %0d: got %b expected %b", cyc, {cpu_gnt, host_gnt}, {g_cpu, g_host}); end
      tests++; if ({cpu_rvalid, host_rvalid} !== {(cyc == exp_rd_cycle) && !exp_rd_host, (cyc == exp_rd_cycle) && exp_rd_host})
        begin fails++; $display("[TB] FAIL rand_rvalid cycle %0d: got %b", cyc, {cpu_rvalid, host_rvalid}); end
      if (cyc == exp_rd_cycle) begin
        rd = exp_rd_host ? host_rdata : cpu_rdata;
        tests++; if (rd !== exp_rd_data) begin fails++; $display("[TB] FAIL rand_rdata: got %h expected %h", rd, exp_rd_data); end
      end
      if (g_cpu || g_host) begin
        wr = g_cpu ? cpu_wr : host_wr;
        a  = g_cpu ? cpu_addr : host_addr;
        if (wr) begin
          ref_mem[a] = g_cpu ? cpu_wdata : host_wdata;
          free_at = cyc + 2;
        end else begin
          exp_rd_cycle = cyc + 2;
          exp_rd_host  = g_host;
          exp_rd_data  = ref_mem[a];
          free_at      = cyc + 3;
        end
        last_host = g_host;
        if (g_cpu) cnt_cpu_m = sat16(cnt_cpu_m); else cnt_host_m = sat16(cnt_host_m);
      end
      @(posedge clk); #1;
      // Requests are held until granted, occasionally withdrawn early.
      if (g_cpu) cpu_req = 1'b0;
      else if (!cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
          cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 19) == 0) cpu_req = 1'b0;
      if (g_host) host_req = 1'b0;
      else if (!host_req) begin
        if ($urandom_range(0, 2) == 0) begin
          host_req = 1'b1; host_wr = 1'($urandom_range(0, 1));
          host_addr = 8'($urandom_range(0, 15)); host_wdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 19) == 0) host_req = 1'b0;
    end
    cpu_req = 1'b0; host_req = 1'b0;
    idle(4);
    tests++; if ({cpu_cnt, host_cnt} !== {16'(cnt_cpu_m), 16'(cnt_host_m)})
      begin fails++; $display("[TB] FAIL rand_cnt: got %0d/%0d expected %0d/%0d", cpu_cnt, host_cnt, cnt_cpu_m, cnt_host_m); end
  endtask

  task automatic test_reset_abort;
    bit ok;
    idle(3);
    cpu_txn(1'b1, 8'h20, 16'hBEEF, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL abort_gnt: got no cpu_gnt expected one"); end
    #2 reset = 1'b0;
    #1;
    tests++; if (mem_wr !== 1'b0) begin fails++; $display("[TB] FAIL abort_mem_wr: got %b expected 0", mem_wr); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    cpu_txn(1'b0, 8'h20, 16'h0000, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL abort_rd_gnt: got no cpu_gnt expected one"); end
    @(negedge clk);
    @(negedge clk);
    tests++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, ref_mem[8'h20]})
      begin fails++; $display("[TB] FAIL abort_readback: got %b/%h expected 1/%h", cpu_rvalid, cpu_rdata, ref_mem[8'h20]); end
    last_host = 1'b0;
    cnt_cpu_m = sat16(cnt_cpu_m);
    @(posedge clk); #1;
    cpu_txn(1'b0, 8'h10, 16'h0000, ok);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      tests++; if ({cpu_rvalid, host_rvalid} !== 2'b00)
        begin fails++; $display("[TB] FAIL abort_no_rvalid: got %b expected 00", {cpu_rvalid, host_rvalid}); end
    end
    tests++; if (cpu_cnt !== 16'(cnt_cpu_m)) begin fails++; $display("[TB] FAIL abort_cnt: got %0d expected %0d", cpu_cnt, cnt_cpu_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    bit ok;
    logic [15:0] d;
    idle(2);
    @(negedge clk);
    force dut.cpu_cnt = 16'hFFFE;
    #1 release dut.cpu_cnt;
    cnt_cpu_m = 65534;
    @(posedge clk); #1;
    tests++; if (cpu_cnt !== 16'(cnt_cpu_m)) begin fails++; $display("[TB] FAIL sat_preload: got %h expected %h", cpu_cnt, 16'(cnt_cpu_m)); end
    repeat (2) begin
      d = 16'($urandom);
      cpu_txn(1'b1, 8'h30, d, ok);
      ref_mem[8'h30] = d;
      last_host = 1'b0;
      cnt_cpu_m = sat16(cnt_cpu_m);
      @(posedge clk); #1;
      tests++; if (!ok || cpu_cnt !== 16'(cnt_cpu_m))
        begin fails++; $display("[TB] FAIL sat_cnt: got %h (gnt %b) expected %h", cpu_cnt, ok, 16'(cnt_cpu_m)); end
    end
    tests++; if (host_cnt !== 16'(cnt_host_m)) begin fails++; $display("[TB] FAIL sat_host_cnt: got %0d expected %0d", host_cnt, cnt_host_m); end
    tests++; if (tb_mem[8'h30] !== ref_mem[8'h30]) begin fails++; $display("[TB] FAIL sat_mem: got %h expected %h", tb_mem[8'h30], ref_mem[8'h30]); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_host_read();
    test_round_robin();
    test_random();
    test_reset_abort();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
